player_move: RTL and testbench
==============================

// Module: player_move
// PURPOSE
//  Tile-based movement controller for one player; the stage directly upstream of the player sprite renderer.
//  Samples the direction buttons once per frame and asks the map logic whether the target tile is free.
//  Walks the sprite 32 px to the next tile and produces the top-left sprite position and animation index for the renderer.
// PARAMETERS
//  MAP_X0      10'd64  screen X of map tile (0,0) top-left pixel
//  MAP_Y0      10'd32  screen Y of map tile (0,0) top-left pixel
//  MAP_W       5'd15   map width in tiles (legal tile_x 0..MAP_W-1)
//  MAP_H       4'd13   map height in tiles (legal tile_y 0..MAP_H-1)
//  START_TX    5'd0    tile_x after reset
//  START_TY    4'd0    tile_y after reset
//  SPEED       2       pixels per frame; must be 1, 2, 4, 8, 16 or 32
//  ANIM_FRAMES 8       frames per walk-animation phase (>=1)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous reset, active low
//  frame_tick  in   1   one-cycle pulse per video frame (end of active area)
//  btn_up      in   1   direction buttons, synchronised and held level
//  btn_down    in   1
//  btn_left    in   1
//  btn_right   in   1
//  req         out  1   map query request
//  req_tx      out  5   queried tile X, stable while req=1
//  req_ty      out  4   queried tile Y, stable while req=1
//  ack         in   1   one-cycle map response pulse; only legal while req=1
//  free        in   1   target tile walkable; valid only when ack=1
//  player_x    out  10  sprite top-left X, drives the renderer centerX input
//  player_y    out  10  sprite top-left Y, drives the renderer centerY input
//  tile_x      out  5   current tile (updated when a step completes)
//  tile_y      out  4
//  sprite_num  out  3   animation index 0..6
//  moving      out  1   high while in MOVE
// BEHAVIOUR
//  Reset (asynchronous, immediate, legal mid-query or mid-move):
//   - state=IDLE, req=0, moving=0, sprite_num=0.
//   - tile=(START_TX,START_TY); player_x=MAP_X0+32*START_TX; player_y=MAP_Y0+32*START_TY.
//  FSM states: IDLE, QUERY, MOVE. All outputs are registered.
//  IDLE:
//   - Acts only on frame_tick.
//   - Direction priority: up > down > left > right; no button held -> stay IDLE.
//   - Target = current tile +/-1 on one axis. Out of bounds (underflow below 0, or >= MAP_W/MAP_H) -> stay IDLE, req stays 0.
//   - Otherwise latch dir, set req=1 and req_tx/req_ty=target on the next edge, and enter QUERY.
//  QUERY:
//   - req, req_tx and req_ty are held until ack.
//   - Cycle after ack: req=0. free=1 -> MOVE, moving=1. free=0 -> IDLE, sprite_num=0.
//   - A frame_tick in the ack cycle is not consumed; motion starts on the next tick.
//   - No timeout; frame_tick is ignored while waiting.
//  MOVE:
//   - Each frame_tick adds/subtracts SPEED on the latched axis and adds SPEED to a 6-bit step counter.
//   - When the counter reaches 32: position equals the target tile exactly; tile_x/tile_y <= target; counter=0.
//   - The cycle after the step completes: IDLE, moving=0. A new step needs the next frame_tick (no same-tick chaining).
//   - Buttons are ignored during MOVE.
//  Animation:
//   - Phase bit toggles when the frame counter reaches ANIM_FRAMES-1 on a MOVE frame_tick.
//   - Counter and phase are cleared on leaving MOVE.
//   - sprite_num: 0 idle; down 1+phase; up 3+phase; left 5; right 6.
//   - sprite_num changes only on clock edges, never mid-line of a frame tick's cycle.
//  Width rules: position arithmetic is 10-bit unsigned; no wrap is possible because moves are bounds-checked first.
// STRUCTURE
//  bomber_pkg:
//   - dir_t enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}, state_t enum.
//   - TILE_SIZE=32; sprite constants SPR_IDLE=0, SPR_DOWN=1, SPR_UP=3, SPR_LEFT=5, SPR_RIGHT=6.
//  Sub-module sprite_anim:
//   - Inputs: clk, reset_n, frame_tick, moving, dir.
//   - Owns the frame counter and phase; outputs sprite_num.
// TESTING
//  T1: reset with START=(2,3), MAP_X0=64, MAP_Y0=32 -> player=(128,128), tile=(2,3), req=0, sprite_num=0.
//  T2: hold btn_right, tick; ack+free=1 two cycles later.
//      -> req_tx=3, req_ty=3; 16 ticks with SPEED=2 -> player_x=160, tile_x=3, moving=0.
//  T3: btn_up at tile_y=0 -> no req ever. btn_left with ack+free=0 -> IDLE, position unchanged, sprite_num=0.
//  T4: btn_up|btn_right together -> req_ty=tile_y-1 (up wins).
//      ANIM_FRAMES=8 -> sprite_num 3 for 8 ticks, then 4, then 3.
//  T5: reset_n low at tick 7 of MOVE -> outputs at reset values within the same cycle.
//      Then drive an ack with frame_tick in the same cycle -> motion begins on the following tick.

Source files
------------

// File: rtl/bomber_pkg.sv
// Shared types and constants for the player movement block.
package bomber_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_QUERY, ST_MOVE} state_t;

  localparam int TILE_SIZE = 32;

  localparam logic [2:0] SPR_IDLE  = 3'd0;
  localparam logic [2:0] SPR_DOWN  = 3'd1;
  localparam logic [2:0] SPR_UP    = 3'd3;
  localparam logic [2:0] SPR_LEFT  = 3'd5;
  localparam logic [2:0] SPR_RIGHT = 3'd6;

endpackage

// File: rtl/sprite_anim.sv
// Walk-animation sequencer: frame counter plus phase bit, decoded to a sprite index.
module sprite_anim
  import bomber_pkg::*;
#(
  parameter int ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       moving,
  input  dir_t       dir,
  output logic [2:0] sprite_num
);

  localparam logic [7:0] LAST_FRAME = 8'(ANIM_FRAMES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  // Count MOVE frame ticks; toggle phase each ANIM_FRAMES ticks; clear outside MOVE.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!moving) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (frame_tick) begin
      if (cnt_q == LAST_FRAME) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Sprite index is a pure decode of flops, so it only changes on clock edges.
  always_comb begin
    sprite_num = SPR_IDLE;
    if (moving) begin
      case (dir)
        DIR_DOWN:  sprite_num = SPR_DOWN + {2'b00, phase_q};
        DIR_UP:    sprite_num = SPR_UP + {2'b00, phase_q};
        DIR_LEFT:  sprite_num = SPR_LEFT;
        DIR_RIGHT: sprite_num = SPR_RIGHT;
        default:   sprite_num = SPR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/player_move.sv
// Tile-based player movement: samples buttons per frame, queries the map,
// then walks the sprite one tile at SPEED pixels per frame.
// Handshake: req rises with req_tx/req_ty and all three hold until the
// single-cycle ack; free is only looked at in the ack cycle.
module player_move
  import bomber_pkg::*;
#(
  parameter logic [9:0] MAP_X0      = 10'd64,
  parameter logic [9:0] MAP_Y0      = 10'd32,
  parameter logic [4:0] MAP_W       = 5'd15,
  parameter logic [3:0] MAP_H       = 4'd13,
  parameter logic [4:0] START_TX    = 5'd0,
  parameter logic [3:0] START_TY    = 4'd0,
  parameter int         SPEED       = 2,
  parameter int         ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       req,
  output logic [4:0] req_tx,
  output logic [3:0] req_ty,
  input  logic       ack,
  input  logic       free,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [4:0] tile_x,
  output logic [3:0] tile_y,
  output logic [2:0] sprite_num,
  output logic       moving,
  output state_t     state_dbg
);

  localparam logic [9:0] PX_RST = 10'(MAP_X0 + TILE_SIZE * START_TX);
  localparam logic [9:0] PY_RST = 10'(MAP_Y0 + TILE_SIZE * START_TY);
  localparam logic [9:0] SPD10  = 10'(SPEED);
  localparam logic [5:0] SPD6   = 6'(SPEED);
  localparam logic [5:0] STEP   = 6'(TILE_SIZE);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic       req_q, req_d;
  logic [4:0] req_tx_q, req_tx_d;
  logic [3:0] req_ty_q, req_ty_d;
  logic [4:0] tile_x_q, tile_x_d;
  logic [3:0] tile_y_q, tile_y_d;
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
  logic [5:0] step_q, step_d;
  logic       moving_q, moving_d;

  dir_t       sel_dir;
  logic       tgt_ok;
  logic [4:0] tgt_tx;
  logic [3:0] tgt_ty;
  logic [5:0] step_sum;

  // Pick the highest-priority held direction and bounds-check its target tile.
  always_comb begin
    sel_dir = DIR_RIGHT;
    if (btn_up)        sel_dir = DIR_UP;
    else if (btn_down) sel_dir = DIR_DOWN;
    else if (btn_left) sel_dir = DIR_LEFT;
    tgt_tx = tile_x_q;
    tgt_ty = tile_y_q;
    tgt_ok = 1'b0;
    case (sel_dir)
      DIR_UP: begin
        tgt_ok = (tile_y_q != 4'd0);
        tgt_ty = tile_y_q - 4'd1;
      end
      DIR_DOWN: begin
        tgt_ok = (({1'b0, tile_y_q} + 5'd1) < {1'b0, MAP_H});
        tgt_ty = tile_y_q + 4'd1;
      end
      DIR_LEFT: begin
        tgt_ok = (tile_x_q != 5'd0);
        tgt_tx = tile_x_q - 5'd1;
      end
      DIR_RIGHT: begin
        tgt_ok = (({1'b0, tile_x_q} + 6'd1) < {1'b0, MAP_W});
        tgt_tx = tile_x_q + 5'd1;
      end
      default: tgt_ok = 1'b0;
    endcase
    tgt_ok = tgt_ok & (btn_up | btn_down | btn_left | btn_right);
  end

  // Next-state and registered-output logic for IDLE / QUERY / MOVE.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    req_d    = req_q;
    req_tx_d = req_tx_q;
    req_ty_d = req_ty_q;
    tile_x_d = tile_x_q;
    tile_y_d = tile_y_q;
    px_d     = px_q;
    py_d     = py_q;
    step_d   = step_q;
    moving_d = moving_q;
    step_sum = step_q + SPD6;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && tgt_ok) begin
          state_d  = ST_QUERY;
          dir_d    = sel_dir;
          req_d    = 1'b1;
          req_tx_d = tgt_tx;
          req_ty_d = tgt_ty;
        end
      end
      ST_QUERY: begin
        // A frame tick coinciding with ack is deliberately not used for motion.
        if (ack) begin
          req_d  = 1'b0;
          step_d = 6'd0;
          if (free) begin
            state_d  = ST_MOVE;
            moving_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_MOVE: begin
        if (frame_tick) begin
          case (dir_q)
            DIR_UP:    py_d = py_q - SPD10;
            DIR_DOWN:  py_d = py_q + SPD10;
            DIR_LEFT:  px_d = px_q - SPD10;
            DIR_RIGHT: px_d = px_q + SPD10;
            default:   px_d = px_q;
          endcase
          if (step_sum == STEP) begin
            step_d   = 6'd0;
            tile_x_d = req_tx_q;
            tile_y_d = req_ty_q;
            state_d  = ST_IDLE;
            moving_d = 1'b0;
          end else begin
            step_d = step_sum;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset may land mid-query or mid-move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      req_q    <= 1'b0;
      req_tx_q <= START_TX;
      req_ty_q <= START_TY;
      tile_x_q <= START_TX;
      tile_y_q <= START_TY;
      px_q     <= PX_RST;
      py_q     <= PY_RST;
      step_q   <= 6'd0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      req_q    <= req_d;
      req_tx_q <= req_tx_d;
      req_ty_q <= req_ty_d;
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      px_q     <= px_d;
      py_q     <= py_d;
      step_q   <= step_d;
      moving_q <= moving_d;
    end
  end

  sprite_anim #(
    .ANIM_FRAMES(ANIM_FRAMES)
  ) u_anim (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .moving    (moving_q),
    .dir       (dir_q),
    .sprite_num(sprite_num)
  );

  assign req       = req_q;
  assign req_tx    = req_tx_q;
  assign req_ty    = req_ty_q;
  assign tile_x    = tile_x_q;
  assign tile_y    = tile_y_q;
  assign player_x  = px_q;
  assign player_y  = py_q;
  assign moving    = moving_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_player_move.sv
// Bench for player_move: directed scenarios plus a randomized walk checked
// against a tile-level model of where the player should be.
module tb_player_move;
  import bomber_pkg::*;

  localparam int X0 = 64;
  localparam int Y0 = 32;
  localparam int W  = 15;
  localparam int H  = 13;
  localparam int STX = 2;
  localparam int STY = 3;
  localparam int SPD = 2;
  localparam int AF  = 8;
  localparam int TICKS_PER_STEP = 32 / SPD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       ack = 1'b0, free = 1'b0;
  logic       req;
  logic [4:0] req_tx;
  logic [3:0] req_ty;
  logic [9:0] player_x, player_y;
  logic [4:0] tile_x;
  logic [3:0] tile_y;
  logic [2:0] sprite_num;
  logic       moving;
  state_t     state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  int mtx, mty;

  player_move #(
    .MAP_X0(10'd64), .MAP_Y0(10'd32), .MAP_W(5'd15), .MAP_H(4'd13),
    .START_TX(5'd2), .START_TY(4'd3), .SPEED(SPD), .ANIM_FRAMES(AF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .req(req), .req_tx(req_tx), .req_ty(req_ty), .ack(ack), .free(free),
    .player_x(player_x), .player_y(player_y), .tile_x(tile_x), .tile_y(tile_y),
    .sprite_num(sprite_num), .moving(moving), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic grant(input logic f);
    ack = 1'b1;
    free = f;
    cyc();
    ack = 1'b0;
    free = 1'b0;
  endtask

  // Full accepted step in one direction, no checking.
  task automatic walk(input logic [3:0] b);
    set_btn(b);
    pulse_tick();
    set_btn(4'b0000);
    cyc();
    grant(1'b1);
    for (int i = 0; i < TICKS_PER_STEP; i++) begin
      pulse_tick();
      cyc();
    end
  endtask

  // ---------------- reference model ----------------
  // Direction chosen by priority up > down > left > right; go=0 when no button or off-map.
  task automatic plan(input logic [3:0] b, output bit go, output int dtx, output int dty,
                      output int spr);
    dtx = 0; dty = 0; spr = 0;
    if (b[3])      begin dty = -1; spr = 3; end
    else if (b[2]) begin dty = 1;  spr = 1; end
    else if (b[1]) begin dtx = -1; spr = 5; end
    else if (b[0]) begin dtx = 1;  spr = 6; end
    go = (b != 4'b0000) && (mtx + dtx >= 0) && (mtx + dtx < W) &&
         (mty + dty >= 0) && (mty + dty < H);
  endtask

  function automatic int anim_spr(input int base, input int ticks_done);
    if (base == 1 || base == 3) return base + ((ticks_done / AF) % 2);
    return base;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    cyc(); cyc();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", req); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got %0b want 0", moving); end
    n_checks++; if (sprite_num !== 3'd0) begin n_fail++; $display("FAIL reset_sprite got %0d want 0", sprite_num); end
    n_checks++; if (player_x !== 10'd128 || player_y !== 10'd128) begin n_fail++; $display("FAIL reset_pos got (%0d,%0d) want (128,128)", player_x, player_y); end
    n_checks++; if (tile_x !== 5'd2 || tile_y !== 4'd3) begin n_fail++; $display("FAIL reset_tile got (%0d,%0d) want (2,3)", tile_x, tile_y); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
    reset_n = 1'b1;
    cyc();
    mtx = STX; mty = STY;
  endtask

  task automatic test_right_step();
    set_btn(4'b0001);
    pulse_tick();
    n_checks++; if (req !== 1'b1 || req_tx !== 5'd3 || req_ty !== 4'd3) begin n_fail++; $display("FAIL right_req got req=%0b (%0d,%0d) want 1 (3,3)", req, req_tx, req_ty); end
    set_btn(4'b0000);
    cyc();
    grant(1'b1);
    n_checks++; if (moving !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL right_enter_move got moving=%0b req=%0b want 1 0", moving, req); end
    for (int i = 1; i <= TICKS_PER_STEP; i++) begin
      pulse_tick();
      n_checks++; if (player_x !== 10'(128 + SPD * i)) begin n_fail++; $display("FAIL right_px tick %0d got %0d want %0d", i, player_x, 128 + SPD * i); end
      if (i < TICKS_PER_STEP) begin
        n_checks++; if (moving !== 1'b1 || tile_x !== 5'd2 || sprite_num !== 3'd6) begin n_fail++; $display("FAIL right_mid tick %0d got moving=%0b tile_x=%0d spr=%0d want 1 2 6", i, moving, tile_x, sprite_num); end
      end
      cyc();
    end
    n_checks++; if (player_x !== 10'd160 || tile_x !== 5'd3 || moving !== 1'b0 || sprite_num !== 3'd0) begin n_fail++; $display("FAIL right_done got px=%0d tile_x=%0d moving=%0b spr=%0d want 160 3 0 0", player_x, tile_x, moving, sprite_num); end
    mtx = 3;
  endtask

  // Up+right held together: up must win; also checks the up-walk animation.
  task automatic test_up_anim();
    int ey;
    for (int s = 0; s < 3; s++) begin
      set_btn(4'b1001);
      pulse_tick();
      n_checks++; if (req !== 1'b1 || req_tx !== 5'(mtx) || req_ty !== 4'(mty - 1)) begin n_fail++; $display("FAIL up_req step %0d got req=%0b (%0d,%0d) want 1 (%0d,%0d)", s, req, req_tx, req_ty, mtx, mty - 1); end
      cyc();
      grant(1'b1);
      for (int i = 1; i <= TICKS_PER_STEP; i++) begin
        pulse_tick();
        ey = Y0 + 32 * mty - SPD * i;
        n_checks++; if (player_y !== 10'(ey)) begin n_fail++; $display("FAIL up_py step %0d tick %0d got %0d want %0d", s, i, player_y, ey); end
        if (i < TICKS_PER_STEP) begin
          n_checks++; if (sprite_num !== 3'(anim_spr(3, i))) begin n_fail++; $display("FAIL up_anim step %0d tick %0d got %0d want %0d", s, i, sprite_num, anim_spr(3, i)); end
        end
        cyc();
      end
      mty = mty - 1;
      n_checks++; if (tile_y !== 4'(mty) || sprite_num !== 3'd0 || req !== 1'b0) begin n_fail++; $display("FAIL up_done step %0d got tile_y=%0d spr=%0d req=%0b want %0d 0 0", s, tile_y, sprite_num, req, mty); end
    end
    set_btn(4'b0000);
  endtask

  task automatic test_bounds();
    set_btn(4'b1000);
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      for (int c = 0; c < 3; c++) begin
        n_checks++; if (req !== 1'b0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL top_edge_req got req=%0b state=%0d want 0 IDLE", req, state_dbg); end
        cyc();
      end
    end
    set_btn(4'b0010);
    pulse_tick();
    set_btn(4'b0000);
    n_checks++; if (req !== 1'b1 || req_tx !== 5'(mtx - 1) || req_ty !== 4'd0) begin n_fail++; $display("FAIL left_req got req=%0b (%0d,%0d) want 1 (%0d,0)", req, req_tx, req_ty, mtx - 1); end
    pulse_tick();
    pulse_tick();
    n_checks++; if (req !== 1'b1 || player_x !== 10'(X0 + 32 * mtx) || moving !== 1'b0) begin n_fail++; $display("FAIL query_hold got req=%0b px=%0d moving=%0b want 1 %0d 0", req, player_x, moving, X0 + 32 * mtx); end
    grant(1'b0);
    n_checks++; if (req !== 1'b0 || moving !== 1'b0 || sprite_num !== 3'd0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL blocked got req=%0b moving=%0b spr=%0d state=%0d want 0 0 0 IDLE", req, moving, sprite_num, state_dbg); end
    n_checks++; if (player_x !== 10'(X0 + 32 * mtx) || tile_x !== 5'(mtx)) begin n_fail++; $display("FAIL blocked_pos got px=%0d tile_x=%0d want %0d %0d", player_x, tile_x, X0 + 32 * mtx, mtx); end
  endtask

  task automatic test_reset_mid_move();
    set_btn(4'b0100);
    pulse_tick();
    set_btn(4'b0000);
    cyc();
    grant(1'b1);
    for (int i = 0; i < 7; i++) begin
      pulse_tick();
      cyc();
    end
    reset_n = 1'b0;
    #1;
    n_checks++; if (player_x !== 10'd128 || player_y !== 10'd128 || tile_x !== 5'd2 || tile_y !== 4'd3) begin n_fail++; $display("FAIL midreset_pos got (%0d,%0d) tile (%0d,%0d) want (128,128) (2,3)", player_x, player_y, tile_x, tile_y); end
    n_checks++; if (moving !== 1'b0 || req !== 1'b0 || sprite_num !== 3'd0) begin n_fail++; $display("FAIL midreset_flags got moving=%0b req=%0b spr=%0d want 0 0 0", moving, req, sprite_num); end
    cyc();
    reset_n = 1'b1;
    cyc();
    mtx = STX; mty = STY;
    // Ack arrives together with a frame tick: that tick must not move the sprite.
    set_btn(4'b0100);
    pulse_tick();
    set_btn(4'b0000);
    n_checks++; if (req !== 1'b1 || req_ty !== 4'd4) begin n_fail++; $display("FAIL ackick_req got req=%0b ty=%0d want 1 4", req, req_ty); end
    cyc();
    frame_tick = 1'b1;
    grant(1'b1);
    frame_tick = 1'b0;
    n_checks++; if (moving !== 1'b1 || player_y !== 10'd128) begin n_fail++; $display("FAIL acktick_nomove got moving=%0b py=%0d want 1 128", moving, player_y); end
    cyc();
    for (int i = 1; i <= TICKS_PER_STEP; i++) begin
      pulse_tick();
      n_checks++; if (player_y !== 10'(128 + SPD * i)) begin n_fail++; $display("FAIL acktick_py tick %0d got %0d want %0d", i, player_y, 128 + SPD * i); end
    end
    mty = 4;
    n_checks++; if (tile_y !== 4'd4 || moving !== 1'b0) begin n_fail++; $display("FAIL acktick_done got tile_y=%0d moving=%0b want 4 0", tile_y, moving); end
  endtask

  // Walk to the bottom-right corner, then confirm down and right are refused.
  task automatic test_edges();
    while (mty < H - 1) begin
      walk(4'b0100);
      mty++;
    end
    while (mtx < W - 1) begin
      walk(4'b0001);
      mtx++;
    end
    n_checks++; if (tile_x !== 5'(W - 1) || tile_y !== 4'(H - 1)) begin n_fail++; $display("FAIL corner_tile got (%0d,%0d) want (%0d,%0d)", tile_x, tile_y, W - 1, H - 1); end
    n_checks++; if (player_x !== 10'(X0 + 32 * (W - 1)) || player_y !== 10'(Y0 + 32 * (H - 1))) begin n_fail++; $display("FAIL corner_pos got (%0d,%0d) want (%0d,%0d)", player_x, player_y, X0 + 32 * (W - 1), Y0 + 32 * (H - 1)); end
    for (int k = 0; k < 2; k++) begin
      set_btn(k == 0 ? 4'b0100 : 4'b0001);
      pulse_tick();
      cyc();
      n_checks++; if (req !== 1'b0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL corner_edge %0d got req=%0b state=%0d want 0 IDLE", k, req, state_dbg); end
    end
    set_btn(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] b;
    bit go;
    int dtx, dty, spr, dly, gap, ex, ey;
    logic f;
    for (int it = 0; it < 40; it++) begin
      b = 4'($urandom_range(0, 15));
      set_btn(b);
      plan(b, go, dtx, dty, spr);
      pulse_tick();
      if (!go) begin
        for (int c = 0; c < 2; c++) begin
          n_checks++; if (req !== 1'b0 || moving !== 1'b0) begin n_fail++; $display("FAIL rnd_noreq it %0d btn %b got req=%0b moving=%0b want 0 0", it, b, req, moving); end
          cyc();
        end
        continue;
      end
      n_checks++; if (req !== 1'b1 || req_tx !== 5'(mtx + dtx) || req_ty !== 4'(mty + dty)) begin n_fail++; $display("FAIL rnd_req it %0d got req=%0b (%0d,%0d) want 1 (%0d,%0d)", it, req, req_tx, req_ty, mtx + dtx, mty + dty); end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        frame_tick = 1'($urandom_range(0, 1));
        cyc();
        frame_tick = 1'b0;
        n_checks++; if (req !== 1'b1 || player_x !== 10'(X0 + 32 * mtx) || player_y !== 10'(Y0 + 32 * mty)) begin n_fail++; $display("FAIL rnd_wait it %0d got req=%0b pos (%0d,%0d)", it, req, player_x, player_y); end
      end
      f = 1'($urandom_range(0, 1));
      grant(f);
      n_checks++; if (req !== 1'b0 || moving !== f) begin n_fail++; $display("FAIL rnd_ack it %0d got req=%0b moving=%0b want 0 %0b", it, req, moving, f); end
      if (f) begin
        for (int i = 1; i <= TICKS_PER_STEP; i++) begin
          pulse_tick();
          ex = X0 + 32 * mtx + dtx * SPD * i;
          ey = Y0 + 32 * mty + dty * SPD * i;
          n_checks++; if (player_x !== 10'(ex) || player_y !== 10'(ey)) begin n_fail++; $display("FAIL rnd_pos it %0d tick %0d got (%0d,%0d) want (%0d,%0d)", it, i, player_x, player_y, ex, ey); end
          if (i < TICKS_PER_STEP) begin
            n_checks++; if (sprite_num !== 3'(anim_spr(spr, i))) begin n_fail++; $display("FAIL rnd_anim it %0d tick %0d got %0d want %0d", it, i, sprite_num, anim_spr(spr, i)); end
          end
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) cyc();
        end
        mtx += dtx;
        mty += dty;
      end
      // Buttons are still held here: no new query until another tick arrives.
      n_checks++; if (req !== 1'b0 || moving !== 1'b0 || sprite_num !== 3'd0) begin n_fail++; $display("FAIL rnd_end it %0d got req=%0b moving=%0b spr=%0d want 0 0 0", it, req, moving, sprite_num); end
      n_checks++; if (tile_x !== 5'(mtx) || tile_y !== 4'(mty)) begin n_fail++; $display("FAIL rnd_tile it %0d got (%0d,%0d) want (%0d,%0d)", it, tile_x, tile_y, mtx, mty); end
      set_btn(4'b0000);
      cyc();
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_right_step();
    test_up_anim();
    test_bounds();
    test_reset_mid_move();
    test_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
